// File: rtl/pipeline_pkg.sv
// Shared pipeline control definitions: state encoding,
// mask polarities and the default pipeline depth.
package pipeline_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic LOCK_WRITE = 1'b1;
  localparam logic CLEAR_ON   = 1'b1;

  localparam int DEF_STAGES = 4;

endpackage

// File: rtl/pipeline_stat_counter.sv
// Saturating 32-bit event counter with enable.
// Only built with PIPELINE_HAZARD_CTRL_STATS_EN defined.
`ifdef PIPELINE_HAZARD_CTRL_STATS_EN
module pipeline_stat_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/pipeline_hazard_ctrl.sv
// Per-stage lock/clear mask generator with multi-cycle stall engine.
// Optional stats counters: PIPELINE_HAZARD_CTRL_STATS_EN.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int STAGES       = DEF_STAGES,
  parameter int BRANCH_STAGE = 2,
  parameter int JUMP_STAGE   = 1,
  parameter int STALL_STAGE  = 1,
  parameter int CNT_W        = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              branch,
  input  logic              jump,
  input  logic              stall_req,
  input  logic [CNT_W-1:0]  stall_len,
  output logic [STAGES-1:0] pipeline_lock,
  output logic [STAGES-1:0] pipeline_clear,
  output logic              stalling,
  output logic [CNT_W-1:0]  stall_remaining
`ifdef PIPELINE_HAZARD_CTRL_STATS_EN
  ,
  output logic [31:0]       stat_stall_cycles,
  output logic [31:0]       stat_flush_events
`endif
);

  if (STAGES < 1) begin : g_bad_stages
    $fatal(1, "STAGES must be >= 1");
  end
  if (BRANCH_STAGE < 1 || BRANCH_STAGE > STAGES) begin : g_bad_br
    $fatal(1, "BRANCH_STAGE out of range 1..STAGES");
  end
  if (JUMP_STAGE < 1 || JUMP_STAGE > STAGES) begin : g_bad_jmp
    $fatal(1, "JUMP_STAGE out of range 1..STAGES");
  end
  if (STALL_STAGE < 1 || STALL_STAGE > STAGES - 1) begin : g_bad_stl
    $fatal(1, "STALL_STAGE out of range 1..STAGES-1");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $fatal(1, "CNT_W must be >= 1");
  end

  localparam logic [STAGES-1:0] ALL1 = {STAGES{1'b1}};
  localparam logic [STAGES-1:0] BR_MASK = ALL1 >> (STAGES - BRANCH_STAGE);
  localparam logic [STAGES-1:0] JMP_MASK = ALL1 >> (STAGES - JUMP_STAGE);
  localparam logic [STAGES-1:0] STL_HOLD = ~(ALL1 << STALL_STAGE);
  localparam logic [STAGES-1:0] STL_BUB = STAGES'(1) << STALL_STAGE;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_m1;
  logic             flush;

  // A zero-length request still costs one stall cycle.
  assign len_m1 = (stall_len == '0) ? '0 : stall_len - 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pipeline_lock  = {STAGES{LOCK_WRITE}};
    pipeline_clear = {STAGES{~CLEAR_ON}};
    stalling       = 1'b0;
    flush          = 1'b0;
    if (reset) begin
      state_d        = RUN;
      cnt_d          = '0;
      pipeline_clear = {STAGES{CLEAR_ON}};
    end else begin
      unique case (state_q)
        RUN: begin
          if (branch) begin
            pipeline_clear = BR_MASK;
            flush          = 1'b1;
          end else if (jump) begin
            pipeline_clear = JMP_MASK;
            flush          = 1'b1;
          end else if (stall_req) begin
            pipeline_lock  = ~STL_HOLD;
            pipeline_clear = STL_BUB;
            stalling       = 1'b1;
            cnt_d          = len_m1;
            state_d        = (len_m1 != '0) ? STALL : RUN;
          end
        end
        STALL: begin
          if (branch) begin
            pipeline_clear = BR_MASK;
            flush          = 1'b1;
            cnt_d          = '0;
            state_d        = RUN;
          end else begin
            pipeline_lock  = ~STL_HOLD;
            pipeline_clear = STL_BUB;
            stalling       = 1'b1;
            cnt_d          = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  // Cycles still to come after the current stall cycle.
  assign stall_remaining = stalling ? cnt_d : '0;

`ifdef PIPELINE_HAZARD_CTRL_STATS_EN
  pipeline_stat_counter u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .en    (stalling),
    .count (stat_stall_cycles)
  );

  pipeline_stat_counter u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .en    (flush),
    .count (stat_flush_events)
  );
`else
  logic unused_flush;
  assign unused_flush = flush;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed checks of mask patterns, stall timing,
// branch/jump priority and async reset behaviour.
module tb_pipeline_hazard_ctrl;

  logic       clock;
  logic       reset;
  logic       branch;
  logic       jump;
  logic       stall_req;
  logic [2:0] stall_len;
  logic [3:0] pipeline_lock;
  logic [3:0] pipeline_clear;
  logic       stalling;
  logic [2:0] stall_remaining;

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] obs;
  logic [11:0] exp;

  assign obs = {pipeline_lock, pipeline_clear, stalling, stall_remaining};

  pipeline_hazard_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .branch          (branch),
    .jump            (jump),
    .stall_req       (stall_req),
    .stall_len       (stall_len),
    .pipeline_lock   (pipeline_lock),
    .pipeline_clear  (pipeline_clear),
    .stalling        (stalling),
    .stall_remaining (stall_remaining)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Move to the middle of the next cycle, away from the edge.
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; branch = 0; jump = 0; stall_req = 0; stall_len = 0;
    #1;
    exp = {4'hF, 4'hF, 1'b0, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset_held got=%h want=%h", obs, exp); end
    cyc();
    exp = {4'hF, 4'hF, 1'b0, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset_edge got=%h want=%h", obs, exp); end
    reset = 1'b0;
    #1;
    exp = {4'hF, 4'h0, 1'b0, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset_release got=%h want=%h", obs, exp); end
  endtask

  task automatic test_flush();
    cyc(); branch = 1; #1;
    exp = {4'hF, 4'h3, 1'b0, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL branch got=%h want=%h", obs, exp); end
    cyc(); branch = 0; #1;
    exp = {4'hF, 4'h0, 1'b0, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL branch_after got=%h want=%h", obs, exp); end
    cyc(); jump = 1; #1;
    exp = {4'hF, 4'h1, 1'b0, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL jump got=%h want=%h", obs, exp); end
    cyc(); branch = 1; jump = 1; stall_req = 1; stall_len = 3; #1;
    exp = {4'hF, 4'h3, 1'b0, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL branch_jump got=%h want=%h", obs, exp); end
    cyc(); branch = 0; #1;
    exp = {4'hF, 4'h1, 1'b0, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL jump_over_stall got=%h want=%h", obs, exp); end
    cyc(); jump = 0; stall_req = 0; stall_len = 0; #1;
    exp = {4'hF, 4'h0, 1'b0, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL flush_idle got=%h want=%h", obs, exp); end
  endtask

  task automatic test_stall3();
    cyc(); stall_req = 1; stall_len = 3; #1;
    exp = {4'hE, 4'h2, 1'b1, 3'd2}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL stall3_c1 got=%h want=%h", obs, exp); end
    cyc(); jump = 1; stall_len = 7; #1;
    exp = {4'hE, 4'h2, 1'b1, 3'd1}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL stall3_c2 got=%h want=%h", obs, exp); end
    cyc(); jump = 0; #1;
    exp = {4'hE, 4'h2, 1'b1, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL stall3_c3 got=%h want=%h", obs, exp); end
    cyc(); stall_req = 0; #1;
    exp = {4'hF, 4'h0, 1'b0, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL stall3_end got=%h want=%h", obs, exp); end
  endtask

  task automatic test_stall0();
    cyc(); stall_req = 1; stall_len = 0; #1;
    exp = {4'hE, 4'h2, 1'b1, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL stall0_c1 got=%h want=%h", obs, exp); end
    cyc(); stall_req = 0; jump = 1; #1;
    exp = {4'hF, 4'h1, 1'b0, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL stall0_run got=%h want=%h", obs, exp); end
    cyc(); jump = 0; #1;
  endtask

  task automatic test_stall_branch();
    cyc(); stall_req = 1; stall_len = 5; #1;
    exp = {4'hE, 4'h2, 1'b1, 3'd4}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL stbr_c1 got=%h want=%h", obs, exp); end
    cyc(); stall_req = 0; branch = 1; #1;
    exp = {4'hF, 4'h3, 1'b0, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL stbr_branch got=%h want=%h", obs, exp); end
    cyc(); branch = 0; #1;
    exp = {4'hF, 4'h0, 1'b0, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL stbr_after got=%h want=%h", obs, exp); end
  endtask

  task automatic test_back_to_back();
    cyc(); stall_req = 1; stall_len = 2; #1;
    exp = {4'hE, 4'h2, 1'b1, 3'd1}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL b2b_c1 got=%h want=%h", obs, exp); end
    cyc(); stall_len = 1; #1;
    exp = {4'hE, 4'h2, 1'b1, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL b2b_c2 got=%h want=%h", obs, exp); end
    cyc(); #1;
    exp = {4'hE, 4'h2, 1'b1, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL b2b_retrig got=%h want=%h", obs, exp); end
    cyc(); stall_req = 0; #1;
    exp = {4'hF, 4'h0, 1'b0, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL b2b_end got=%h want=%h", obs, exp); end
  endtask

  task automatic test_stall_max();
    int n;
    n = 0;
    cyc(); stall_req = 1; stall_len = 7; #1;
    for (int i = 0; i < 12; i++) begin
      if (stalling === 1'b1) n++;
      cyc(); stall_req = 0; #1;
    end
    vectors++;
    if (n != 7) begin miscompares++; $display("FAIL stall7_len got=%0d want=7", n); end
  endtask

  task automatic test_reset_midstall();
    cyc(); stall_req = 1; stall_len = 4; #1;
    exp = {4'hE, 4'h2, 1'b1, 3'd3}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL rst_c1 got=%h want=%h", obs, exp); end
    cyc(); stall_req = 0; #1;
    exp = {4'hE, 4'h2, 1'b1, 3'd2}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL rst_c2 got=%h want=%h", obs, exp); end
    reset = 1; #1;
    exp = {4'hF, 4'hF, 1'b0, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL rst_async got=%h want=%h", obs, exp); end
    cyc(); reset = 0; #1;
    exp = {4'hF, 4'h0, 1'b0, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL rst_release got=%h want=%h", obs, exp); end
    cyc(); jump = 1; #1;
    exp = {4'hF, 4'h1, 1'b0, 3'd0}; vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL rst_run got=%h want=%h", obs, exp); end
    cyc(); jump = 0; #1;
  endtask

  initial begin
    test_reset();
    test_flush();
    test_stall3();
    test_stall0();
    test_stall_branch();
    test_back_to_back();
    test_stall_max();
    test_reset_midstall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised pipeline control unit generating per-stage write-enable (`pipeline_lock`) and synchronous-clear (`pipeline_clear`) masks for an N-stage in-order pipeline. Successor to the fixed 4-stage branch-flush controller. Adds a multi-cycle stall engine with an internal down-counter, separate jump and branch flush depths, and defined priority between flush and stall. Sits beside the pipeline registers and drives their write/clear inputs directly.

## Interface
- `STAGES`, 4: number of pipeline registers controlled. Bit 0 = IF/ID, bit STAGES-1 = last register.
- `BRANCH_STAGE`, 2: branch flush clears bits [BRANCH_STAGE-1:0]. Legal range 1..STAGES.
- `JUMP_STAGE`, 1: jump flush clears bits [JUMP_STAGE-1:0]. Legal range 1..STAGES.
- `STALL_STAGE`, 1: a stall holds bits [STALL_STAGE-1:0] and clears bit STALL_STAGE (bubble). Legal range 1..STAGES-1.
- `CNT_W`, 3: width of the stall length and counter.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `branch` in 1: taken branch resolved this cycle.
- `jump` in 1: jump resolved this cycle.
- `stall_req` in 1: stall request, sampled in RUN only.
- `stall_len` in CNT_W: requested stall length in cycles; 0 is treated as 1.
- `pipeline_lock` out STAGES: 1 = register may write, 0 = hold.
- `pipeline_clear` out STAGES: 1 = clear register at next edge, 0 = normal.
- `stalling` out 1: high on every cycle a stall pattern is driven.
- `stall_remaining` out CNT_W: stall cycles left after the current one.

## Operation
- FSM has two states: RUN and STALL. The register `cnt` (CNT_W bits) drives `stall_remaining`.
- Outputs are combinational from state, `cnt` and the inputs. No added delay.
- Default pattern: lock all 1, clear all 0.
- Branch pattern: lock all 1; clear = (1<<BRANCH_STAGE)-1.
- Jump pattern: lock all 1; clear = (1<<JUMP_STAGE)-1.
- Stall pattern:
  - lock bits [STALL_STAGE-1:0] = 0, others 1;
  - clear bit STALL_STAGE = 1, others 0;
  - `stalling` = 1.
- Priority in RUN: branch > jump > stall_req > default.
- RUN with accepted stall_req:
  - L = max(stall_len, 1).
  - Stall pattern is driven this cycle. `cnt` loads L-1.
  - Next state is STALL if L-1 > 0, else RUN.
- STALL:
  - Drives the stall pattern and decrements `cnt` each edge.
  - When `cnt` == 1, it returns to RUN at the next edge with `cnt` = 0.
  - The total number of stall cycles equals L.
- Branch in STALL:
  - Branch pattern replaces the stall pattern for that cycle and `stalling` = 0.
  - `cnt` is cleared and the next state is RUN.
- In STALL, jump and stall_req are ignored. There is no extension or re-trigger; the stalled instruction re-presents its jump afterwards.
- Simultaneous branch + jump: the branch pattern only (superset when BRANCH_STAGE ≥ JUMP_STAGE; otherwise still branch).
- While `reset` is high: state RUN, `cnt` 0, lock all 1, clear all 1 (whole pipeline cleared), `stalling` 0.
- Reset asserted mid-stall aborts the stall immediately.

## Timing
- Zero-latency response: the masks reflect `branch`/`jump`/`stall_req` in the same cycle. Pipeline registers act on them at the next rising edge.
- A stall of length L produces exactly L consecutive cycles with `stalling` = 1, unless a branch cuts it short.
- After a stall, the first default-pattern cycle is the cycle after `cnt` reaches 0.
- Async reset: state and counters change without a clock edge. Release is synchronous to the next edge in RUN.

## Configuration
- `PIPELINE_HAZARD_CTRL_STATS_EN` defined: adds 32-bit outputs `stat_stall_cycles` and `stat_flush_events`.
  - `stat_stall_cycles` increments on every `stalling` cycle.
  - `stat_flush_events` increments on every cycle driving a branch or jump pattern.
  - Both saturate at all-ones and reset to 0.
- Macro undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package `pipeline_pkg`:
  - state encoding (RUN=0, STALL=1);
  - lock/clear polarity constants (LOCK_WRITE=1, CLEAR_ON=1);
  - default STAGES.
- Parameter legality is checked at elaboration; an illegal value is a fatal elaboration error.
- No sub-module required. The optional stats counters form a natural sub-module: `pipeline_stat_counter` (saturating 32-bit counter with enable), instantiated twice.

## Test plan
- Reset held, then released, with defaults: lock 4'b1111, clear 4'b1111 during reset; 4'b1111/4'b0000 after.
- `branch`=1 for one cycle in RUN: clear 4'b0011, lock 4'b1111 that cycle only; `jump` alone gives clear 4'b0001.
- `stall_req`=1, `stall_len`=3:
  - lock 4'b1110 and clear 4'b0010 for exactly 3 cycles;
  - `stall_remaining` reads 2, 1, 0;
  - a repeated `stall_req` during the stall is ignored.
- `stall_len`=0: exactly one stall cycle, state stays RUN.
- Stall of length 5 with `branch` in stall cycle 2:
  - that cycle gives clear 4'b0011, lock 4'b1111, `stalling` 0;
  - next cycle is the default pattern.
- Stall of length 4 with `reset` pulsed in cycle 2: outputs go to the reset pattern immediately; after release, RUN with `cnt` 0. With STATS_EN, the counters read 0.
